ibex_hpm_event_ctrl: RTL

Controller for a bank of performance counters built from the single-counter primitive. It holds each counter's event-select, inhibit and overflow-interrupt configuration, and registers the raw event strobes. It produces one increment strobe per counter and detects wrap-around to raise a sticky overflow flag and an interrupt. It sits between the core's event sources and CSR file on one side and the counter instances on the other.

---
 rtl/ibex_hpm_event_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ibex_hpm_event_ctrl.sv
// Event-select, inhibit and overflow/interrupt controller for a bank of HPM counters.
// Registers raw event strobes, produces per-counter increment strobes and sticky overflow flags.
module ibex_hpm_event_ctrl #(
    parameter int unsigned NumCounters  = 4,
    parameter int unsigned NumEvents    = 16,
    parameter int unsigned CounterWidth = 40,
    localparam int unsigned SelW        = $clog2(NumEvents),
    localparam int unsigned IdxW        = (NumCounters > 1) ? $clog2(NumCounters) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumEvents-1:0]        event_i,
    input  logic                        sel_we_i,
    input  logic [IdxW-1:0]             sel_idx_i,
    input  logic [SelW-1:0]             sel_wdata_i,
    input  logic                        inhibit_we_i,
    input  logic [NumCounters-1:0]      inhibit_wdata_i,
    input  logic                        ovf_we_i,
    input  logic [NumCounters-1:0]      ovf_wdata_i,
    input  logic                        irq_en_we_i,
    input  logic [NumCounters-1:0]      irq_en_wdata_i,
    input  logic [NumCounters-1:0]      counter_wr_i,
    input  logic [64*NumCounters-1:0]   counter_val_i,
    output logic [NumCounters-1:0]      counter_inc_o,
    output logic [SelW*NumCounters-1:0] event_sel_o,
    output logic [NumCounters-1:0]      inhibit_o,
    output logic [NumCounters-1:0]      ovf_o,
    output logic [NumCounters-1:0]      irq_en_o,
    output logic                        irq_o
);

    logic [NumEvents-1:0]   event_q;
    logic [SelW-1:0]        sel_q [NumCounters];
    logic [SelW-1:0]        sel_d [NumCounters];
    logic [NumCounters-1:0] inhibit_q, inhibit_d;
    logic [NumCounters-1:0] ovf_q, ovf_d;
    logic [NumCounters-1:0] irq_en_q, irq_en_d;
    logic [NumCounters-1:0] inc_s, wrap_s;
    logic                   unused_val_s;

    // Bits of counter_val_i above CounterWidth carry no meaning here.
    assign unused_val_s = ^counter_val_i;

    // Increment strobes and wrap detection, derived from registered state only (plus counter value).
    always_comb begin
        inc_s  = {NumCounters{1'b0}};
        wrap_s = {NumCounters{1'b0}};
        for (int i = 0; i < int'(NumCounters); i++) begin
            if ((sel_q[i] != {SelW{1'b0}}) && (int'(sel_q[i]) < int'(NumEvents))) begin
                inc_s[i] = ~inhibit_q[i] & event_q[sel_q[i]];
            end else begin
                inc_s[i] = 1'b0;
            end
            wrap_s[i] = inc_s[i] & ~counter_wr_i[i] & (&counter_val_i[64*i +: CounterWidth]);
        end
    end

    // Configuration next-state; an index beyond the bank matches no counter and is dropped.
    always_comb begin
        for (int i = 0; i < int'(NumCounters); i++) begin
            if (sel_we_i && (int'(sel_idx_i) == i)) begin
                sel_d[i] = sel_wdata_i;
            end else begin
                sel_d[i] = sel_q[i];
            end
        end
        if (inhibit_we_i) begin
            inhibit_d = inhibit_wdata_i;
        end else begin
            inhibit_d = inhibit_q;
        end
        if (irq_en_we_i) begin
            irq_en_d = irq_en_wdata_i;
        end else begin
            irq_en_d = irq_en_q;
        end
        // A hardware wrap always overrides a software write so no overflow is lost.
        if (ovf_we_i) begin
            ovf_d = ovf_wdata_i | wrap_s;
        end else begin
            ovf_d = ovf_q | wrap_s;
        end
    end

    // State registers with asynchronous reset; counters start inhibited.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            event_q   <= {NumEvents{1'b0}};
            inhibit_q <= {NumCounters{1'b1}};
            ovf_q     <= {NumCounters{1'b0}};
            irq_en_q  <= {NumCounters{1'b0}};
            for (int i = 0; i < int'(NumCounters); i++) begin
                sel_q[i] <= {SelW{1'b0}};
            end
        end else begin
            event_q   <= event_i;
            inhibit_q <= inhibit_d;
            ovf_q     <= ovf_d;
            irq_en_q  <= irq_en_d;
            for (int i = 0; i < int'(NumCounters); i++) begin
                sel_q[i] <= sel_d[i];
            end
        end
    end

    // Readback packing.
    always_comb begin
        event_sel_o = {(SelW*NumCounters){1'b0}};
        for (int i = 0; i < int'(NumCounters); i++) begin
            event_sel_o[SelW*i +: SelW] = sel_q[i];
        end
    end

    assign counter_inc_o = inc_s;
    assign inhibit_o     = inhibit_q;
    assign ovf_o         = ovf_q;
    assign irq_en_o      = irq_en_q;
    assign irq_o         = |(ovf_q & irq_en_q);

endmodule
